// File: rtl/deserializer.sv
// deserializer: collects an MSB-first serial bit stream, qualified by a valid
// strobe, into a left-aligned parallel word with a bit count. A frame is one
// contiguous run of valid bits, 1..WIDTH long. Frames shorter than MIN_LEN are
// dropped and flagged. Full frames may be followed back-to-back by the next
// frame with no gap cycle.
module deserializer #(
    parameter int WIDTH   = 16,
    parameter int MOD_W   = $clog2(WIDTH),
    parameter int MIN_LEN = 3
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             ser_data_i,
    input  logic             ser_data_val_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [MOD_W-1:0] deser_data_mod_o,
    output logic             deser_data_val_o,
    output logic             len_err_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // The counter is one bit wider than the mod output so it can hold WIDTH.
    // Truncating WIDTH to MOD_W bits yields the "0 means full word" encoding.
    localparam logic [MOD_W:0]   CNT_ONE  = (MOD_W+1)'(1);
    localparam logic [MOD_W:0]   CNT_FULL = (MOD_W+1)'(WIDTH);
    localparam logic [MOD_W:0]   CNT_MIN  = (MOD_W+1)'(MIN_LEN);
    localparam logic [MOD_W-1:0] TOP_IDX  = MOD_W'(WIDTH - 1);

    state_t           state;
    logic [MOD_W:0]   bit_cnt;
    logic [WIDTH-1:0] shift_reg;

    // Frame assembly FSM: places each bit at its left-aligned position and
    // emits or drops the frame when the run ends or the word fills.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state            <= IDLE;
            bit_cnt          <= '0;
            shift_reg        <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
            len_err_o        <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            len_err_o        <= 1'b0;
            case (state)
                IDLE: begin
                    if (ser_data_val_i) begin
                        shift_reg <= {ser_data_i, {(WIDTH-1){1'b0}}};
                        bit_cnt   <= CNT_ONE;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == CNT_FULL) begin
                        // Word is full: emit it; a bit arriving now opens the next frame.
                        deser_data_o     <= shift_reg;
                        deser_data_mod_o <= '0;
                        deser_data_val_o <= 1'b1;
                        if (ser_data_val_i) begin
                            shift_reg <= {ser_data_i, {(WIDTH-1){1'b0}}};
                            bit_cnt   <= CNT_ONE;
                        end else begin
                            shift_reg <= '0;
                            bit_cnt   <= '0;
                            state     <= IDLE;
                        end
                    end else if (ser_data_val_i) begin
                        shift_reg[TOP_IDX - bit_cnt[MOD_W-1:0]] <= ser_data_i;
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end else begin
                        // Run ended early: emit if long enough, otherwise flag and drop.
                        if (bit_cnt >= CNT_MIN) begin
                            deser_data_o     <= shift_reg;
                            deser_data_mod_o <= bit_cnt[MOD_W-1:0];
                            deser_data_val_o <= 1'b1;
                        end else begin
                            len_err_o <= 1'b1;
                        end
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state == SHIFT);

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the serializer: collects an MSB-first serial bit stream qualified by a valid strobe into a parallel word.
- A frame is one contiguous run of valid bits, 1..WIDTH long. The block reports the word left-aligned, together with its bit count, in the same data/mod encoding the serializer accepts.
- Sits on the far end of the serial link: ser_data_val_i/ser_data_i are driven by the serializer's ser_data_val_o/ser_data_o. The parallel outputs feed the downstream word sink.

Parameters:
- WIDTH, 16, maximum frame length in bits and width of the parallel output.
- MOD_W, $clog2(WIDTH), width of the bit-count output.
- MIN_LEN, 3, shortest legal frame in bits; shorter frames are discarded. This matches the serializer, which ignores mods 1 and 2.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- arst_n_i  input  1  asynchronous active-low reset (assert async, release sync to clk_i externally).
- ser_data_i  input  1  serial data bit, sampled when ser_data_val_i=1.
- ser_data_val_i  input  1  bit-valid strobe; a contiguous high run forms one frame.
- deser_data_o  output  WIDTH  received word, left-aligned; the first bit received is bit WIDTH-1 and unreceived low bits are 0.
- deser_data_mod_o  output  MOD_W  bit count of the word; 0 means WIDTH bits.
- deser_data_val_o  output  1  one-cycle pulse; deser_data_o and deser_data_mod_o are valid in this cycle.
- len_err_o  output  1  one-cycle pulse when a frame shorter than MIN_LEN is dropped.
- busy_o  output  1  high while a frame is partially received.

Behaviour:
- Reset (arst_n_i=0), applied immediately and asynchronously:
  - state=IDLE, bit counter=0, shift register=0.
  - deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, len_err_o=0, busy_o=0.
- States:
  - IDLE: no bits held. If ser_data_val_i=1: capture the bit into position WIDTH-1, set count=1, go to SHIFT.
  - SHIFT, ser_data_val_i=1 and count<WIDTH: store the bit at position WIDTH-1-count, count+1.
  - SHIFT, count==WIDTH (full): emit the frame (deser_data_val_o=1, mod=0).
    - If ser_data_val_i=1 in that same cycle, the bit starts the next frame: position WIDTH-1, count=1, stay in SHIFT. This allows back-to-back frames with no gap cycle.
    - Otherwise count=0, go to IDLE.
  - SHIFT, ser_data_val_i=0 and count<WIDTH: end of frame.
    - If count>=MIN_LEN: emit the frame with mod=count.
    - Else: pulse len_err_o and leave outputs unchanged.
    - In both cases count=0, clear the shift register, go to IDLE.
- Latency: deser_data_val_o rises one clock after the edge that sampled the frame's last bit for a full frame. For a short frame it rises on the edge that samples ser_data_val_i=0.
- Outputs are registered. deser_data_o and deser_data_mod_o hold their value until the next emitted frame; they are not cleared after the pulse.
- deser_data_val_o and len_err_o are never high in the same cycle.
- busy_o = (state==SHIFT).
- Counter width is MOD_W+1 internally so it can hold WIDTH. Only the low MOD_W bits go to deser_data_mod_o, which gives 0 for WIDTH.
- No backpressure: the sink must accept every deser_data_val_o pulse.
- Reset mid-frame: the partial frame is discarded with no val or err pulse. The next valid bit after reset release starts a new frame.

Test Plan:
- Reset: hold arst_n_i=0 for 2 cycles with ser_data_val_i toggling -> all outputs 0 and busy_o=0 throughout, including asynchronously before the first clock edge.
- Short frames: send 3 bits 1,0,1 then val low -> one pulse with deser_data_o=16'hA000, mod=3. Repeat with 4 bits 1,1,0,1 -> 16'hD000, mod=4. Repeat with 5 bits 1,1,1,0,1 -> 16'hE800, mod=5.
- Full frame: 16 bits of 16'h5B82, MSB first -> pulse one cycle after the 16th bit with data=16'h5B82 and mod=0; busy_o falls in the same cycle.
- Back-to-back: 32 consecutive valid bits 16'h5B82 then 16'hB800 -> two pulses exactly 16 cycles apart with those values, and busy_o never drops between them.
- Too short: 2-bit frame 1,1 -> len_err_o pulses once, no deser_data_val_o, data/mod keep their previous values. A following 6-bit frame 0,1,1,1,0,1 -> 16'h7400, mod=6.
- Reset mid-frame: assert arst_n_i after 7 of 16 bits -> no pulse. A fresh 8-bit frame 8'hB8 after release -> 16'hB800, mod=8.
